// File: rtl/proc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle accumulator control unit.
// These cover the FSM states, the instruction classes, the modes, the opcodes and the ALU codes.
package proc_ctrl_pkg;

  typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} state_t;

  typedef enum logic [2:0] {C_LD, C_CP, C_UNARY, C_BINARY, C_IMM, C_ILLEGAL} instr_class_t;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_REG  = 2'b00;
  localparam logic [MODE_W-1:0] MODE_ADDI = 2'b01;
  localparam logic [MODE_W-1:0] MODE_ILL  = 2'b10;
  localparam logic [MODE_W-1:0] MODE_SUBI = 2'b11;

  localparam logic [OP_W-1:0] OP_LD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_CP  = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0011;
  localparam logic [OP_W-1:0] OP_INV = 4'b0100;
  localparam logic [OP_W-1:0] OP_FLP = 4'b0101;
  localparam logic [OP_W-1:0] OP_AND = 4'b0110;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0111;
  localparam logic [OP_W-1:0] OP_XOR = 4'b1000;
  localparam logic [OP_W-1:0] OP_LSL = 4'b1001;
  localparam logic [OP_W-1:0] OP_LSR = 4'b1010;
  localparam logic [OP_W-1:0] OP_ASR = 4'b1011;

  localparam logic [OP_W-1:0] ALU_ADD = OP_ADD;
  localparam logic [OP_W-1:0] ALU_SUB = OP_SUB;

endpackage

// File: rtl/proc_ctrl_decode.sv
// Combinational instruction decoder: IR -> class, register fields, ALU code, zero-extended immediate.
module proc_ctrl_decode
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned RA_W   = 2
) (
  input  logic [DATA_W-1:0] ir,
  output instr_class_t      cls,
  output logic [RA_W-1:0]   rx,
  output logic [RA_W-1:0]   ry,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] imm
);

  logic [MODE_W-1:0] mode;
  logic [OP_W-1:0]   op;

  assign mode = ir[MODE_W-1:0];
  assign op   = ir[OP_W+1:2];
  assign rx   = ir[DATA_W-1 -: RA_W];
  assign ry   = ir[DATA_W-1-RA_W -: RA_W];

  // The immediate field overlaps Ry and op; it is only meaningful in the add/sub-immediate modes
  always_comb begin
    cls    = C_ILLEGAL;
    alu_op = op;
    imm    = '0;
    unique case (mode)
      MODE_REG: begin
        case (op)
          OP_LD:                   cls = C_LD;
          OP_CP:                   cls = C_CP;
          OP_INV, OP_FLP:          cls = C_UNARY;
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_XOR, OP_LSL, OP_LSR, OP_ASR: cls = C_BINARY;
          default:                 cls = C_ILLEGAL;
        endcase
      end
      MODE_ADDI: begin
        cls    = C_IMM;
        alu_op = ALU_ADD;
        imm    = DATA_W'(ir[DATA_W-1-RA_W:2]);
      end
      MODE_SUBI: begin
        cls    = C_IMM;
        alu_op = ALU_SUB;
        imm    = DATA_W'(ir[DATA_W-1-RA_W:2]);
      end
      MODE_ILL: cls = C_ILLEGAL;
      default:  cls = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/proc_control_fsm.sv
// Multi-cycle control unit: latches an instruction and sequences T1..T3 datapath enables.
// Define PROC_CTRL_PERF_CNT_EN to build the retired-instruction counter.
module proc_control_fsm
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned RA_W   = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic [DATA_W-1:0] instr,
  output logic              ir_in,
  output logic [RA_W-1:0]   rin,
  output logic [RA_W-1:0]   rout,
  output logic              enw,
  output logic              enr,
  output logic              ain,
  output logic              gin,
  output logic              gout,
  output logic              ext,
  output logic              imm_oe,
  output logic [DATA_W-1:0] imm,
  output logic [3:0]        alu_op,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  instr_cnt
);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] ir;
  instr_class_t      cls;
  logic [RA_W-1:0]   rx, ry;
  logic [OP_W-1:0]   d_alu_op;
  logic [DATA_W-1:0] d_imm;

  proc_ctrl_decode #(.DATA_W(DATA_W), .RA_W(RA_W)) u_decode (
    .ir     (ir),
    .cls    (cls),
    .rx     (rx),
    .ry     (ry),
    .alu_op (d_alu_op),
    .imm    (d_imm)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && run) ir <= instr;
    end
  end

  // Outputs are decoded from state+IR and held at zero whenever reset is asserted
  always_comb begin
    state_nxt = state;
    ir_in     = 1'b0;
    rin       = '0;
    rout      = '0;
    enw       = 1'b0;
    enr       = 1'b0;
    ain       = 1'b0;
    gin       = 1'b0;
    gout      = 1'b0;
    ext       = 1'b0;
    imm_oe    = 1'b0;
    imm       = '0;
    alu_op    = '0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    if (reset_n) begin
      busy = (state != S_IDLE);
      imm  = d_imm;
      unique case (state)
        S_IDLE: begin
          ir_in = 1'b1;
          if (run) state_nxt = S_T1;
        end
        S_T1: begin
          state_nxt = S_T2;
          case (cls)
            C_LD: begin
              ext = 1'b1; enw = 1'b1; rin = rx; done = 1'b1;
              state_nxt = S_IDLE;
            end
            C_CP: begin
              enr = 1'b1; rout = ry; enw = 1'b1; rin = rx; done = 1'b1;
              state_nxt = S_IDLE;
            end
            C_UNARY: begin
              enr = 1'b1; rout = ry; gin = 1'b1; alu_op = d_alu_op;
            end
            C_BINARY, C_IMM: begin
              enr = 1'b1; rout = rx; ain = 1'b1;
            end
            default: begin
              err = 1'b1;
              state_nxt = S_IDLE;
            end
          endcase
        end
        S_T2: begin
          if (cls == C_UNARY) begin
            gout = 1'b1; enw = 1'b1; rin = rx; done = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            gin    = 1'b1;
            alu_op = d_alu_op;
            if (cls == C_IMM) begin
              imm_oe = 1'b1;
            end else begin
              enr  = 1'b1;
              rout = ry;
            end
            state_nxt = S_T3;
          end
        end
        S_T3: begin
          gout = 1'b1; enw = 1'b1; rin = rx; done = 1'b1;
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

`ifdef PROC_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n)  cnt_q <= '0;
    else if (done) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign instr_cnt = reset_n ? cnt_q : '0;
`else
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_proc_control_fsm.sv
// Directed bench for proc_control_fsm: per-cycle comparison against a field-arithmetic model of
// the instruction timing, plus literal pins on the model and on selected DUT values.
module tb_proc_control_fsm;

  typedef struct packed {
    logic       ir_in;
    logic [1:0] rin;
    logic [1:0] rout;
    logic       enw, enr, ain, gin, gout, ext, imm_oe;
    logic [9:0] imm;
    logic [3:0] alu_op;
    logic       busy, done, err;
    logic [3:0] cnt;
  } outv_t;

  logic       clk, reset_n, run;
  logic [9:0] instr;
  logic       ir_in, enw, enr, ain, gin, gout, ext, imm_oe, busy, done, err;
  logic [1:0] rin, rout;
  logic [9:0] imm;
  logic [3:0] alu_op, instr_cnt;

  outv_t got, exp;
  string tag;
  bit    chk_en;
  int    total, bad;
  int    cnt_m;
  logic [9:0] last_ir;

  proc_control_fsm #(.DATA_W(10), .RA_W(2), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .instr(instr),
    .ir_in(ir_in), .rin(rin), .rout(rout), .enw(enw), .enr(enr),
    .ain(ain), .gin(gin), .gout(gout), .ext(ext), .imm_oe(imm_oe),
    .imm(imm), .alu_op(alu_op), .busy(busy), .done(done), .err(err),
    .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign got = {ir_in, rin, rout, enw, enr, ain, gin, gout, ext, imm_oe,
                imm, alu_op, busy, done, err, instr_cnt};

  // Instruction timing model, derived from the field values by arithmetic
  function automatic int nsteps(input logic [9:0] i);
    int iv = int'(i);
    int mode = iv % 4;
    int op = (iv / 4) % 16;
    if (mode == 2) return 1;
    if (mode != 0) return 3;
    if (op <= 1) return 1;
    if (op == 4 || op == 5) return 2;
    if (op <= 11) return 3;
    return 1;
  endfunction

  function automatic bit legal(input logic [9:0] i);
    int iv = int'(i);
    int mode = iv % 4;
    int op = (iv / 4) % 16;
    return (mode != 2) && !(mode == 0 && op >= 12);
  endfunction

  function automatic logic [9:0] imm_of(input logic [9:0] i);
    int iv = int'(i);
    int mode = iv % 4;
    return (mode == 1 || mode == 3) ? 10'((iv / 4) % 64) : 10'd0;
  endfunction

  function automatic outv_t idle_rec(input logic [9:0] lir, input int c);
    outv_t o = '0;
    o.ir_in = 1'b1;
    o.imm   = imm_of(lir);
    o.cnt   = 4'(c);
    return o;
  endfunction

  function automatic outv_t step_of(input logic [9:0] i, input int k, input int c);
    int iv = int'(i);
    int rx = iv / 256;
    int ry = (iv / 64) % 4;
    int mode = iv % 4;
    int op = (iv / 4) % 16;
    int n = nsteps(i);
    bit immi = (mode == 1 || mode == 3);
    int aop = (mode == 1) ? 2 : (mode == 3) ? 3 : op;
    outv_t o = '0;
    o.busy = 1'b1;
    o.cnt  = 4'(c);
    o.imm  = imm_of(i);
    if (!legal(i)) begin
      o.err = 1'b1;
      return o;
    end
    if (k == n - 1) begin
      o.done = 1'b1; o.enw = 1'b1; o.rin = 2'(rx);
      if (n == 1) begin
        if (op == 0) o.ext = 1'b1;
        else begin o.enr = 1'b1; o.rout = 2'(ry); end
      end else o.gout = 1'b1;
    end else if (n == 2) begin
      o.enr = 1'b1; o.rout = 2'(ry); o.gin = 1'b1; o.alu_op = 4'(aop);
    end else if (k == 0) begin
      o.enr = 1'b1; o.rout = 2'(rx); o.ain = 1'b1;
    end else begin
      o.gin = 1'b1; o.alu_op = 4'(aop);
      if (immi) o.imm_oe = 1'b1;
      else begin o.enr = 1'b1; o.rout = 2'(ry); end
    end
    return o;
  endfunction

  // Per-cycle compare against the expected record, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL cyc_%s t=%0t got=%h exp=%h", tag, $time, got, exp);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, g, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [9:0] i);
    if (legal(i)) begin
`ifdef PROC_CTRL_PERF_CNT_EN
      cnt_m = (cnt_m + 1) % 16;
`endif
    end
  endtask

  task automatic do_instr(input logic [9:0] i, input bit hold);
    exp = idle_rec(last_ir, cnt_m);
    tag = "idle";
    run = 1'b1;
    instr = i;
    tick();
    last_ir = i;
    if (hold) instr = 10'b11_00000000;
    else run = 1'b0;
    for (int k = 0; k < nsteps(i); k++) begin
      exp = step_of(i, k, cnt_m);
      $sformat(tag, "%h_t%0d", i, k + 1);
      tick();
    end
    run = 1'b0;
    retire(i);
    exp = idle_rec(last_ir, cnt_m);
    tag = "idle";
  endtask

  localparam logic [9:0] LD_R2 = 10'b10_00000000;
  localparam logic [9:0] ADD13 = 10'b01_11_0010_00;
  localparam logic [9:0] ADDI  = 10'b00_001101_01;
  localparam logic [9:0] SUBI  = 10'b00_001101_11;
  localparam logic [9:0] CP12  = 10'b01_10_0001_00;
  localparam logic [9:0] INV31 = 10'b11_01_0100_00;
  localparam logic [9:0] XOR21 = 10'b10_01_1000_00;
  localparam logic [9:0] ASR03 = 10'b00_11_1011_00;
  localparam logic [9:0] ILL10 = 10'b01_01_0011_10;
  localparam logic [9:0] ILLOP = 10'b00_00_1100_00;

  initial begin
    outv_t s;
    total = 0; bad = 0; cnt_m = 0; last_ir = '0;
    reset_n = 1'b0; run = 1'b0; instr = '0;
    exp = '0; tag = "reset"; chk_en = 1'b1;

    // Literal pins on the model
    s = step_of(LD_R2, 0, 0);
    chk("pin_ld", 32'({s.ext, s.enw, s.rin, s.done, s.enr}), 32'(6'b1_1_10_1_0));
    s = step_of(ADD13, 0, 0);
    chk("pin_add_t1", 32'({s.rout, s.ain, s.enr, s.gin}), 32'(5'b01_1_1_0));
    s = step_of(ADD13, 1, 0);
    chk("pin_add_t2", 32'({s.rout, s.gin, s.alu_op, s.ain}), 32'(8'b11_1_0010_0));
    s = step_of(ADD13, 2, 0);
    chk("pin_add_t3", 32'({s.gout, s.enw, s.rin, s.done}), 32'(5'b1_1_01_1));
    s = step_of(ADDI, 1, 0);
    chk("pin_addi_t2", 32'({s.imm_oe, s.imm, s.alu_op, s.enr}), 32'({1'b1, 10'd13, 4'd2, 1'b0}));
    s = step_of(SUBI, 1, 0);
    chk("pin_subi_t2", 32'({s.imm_oe, s.alu_op}), 32'({1'b1, 4'd3}));
    s = step_of(ILL10, 0, 0);
    chk("pin_ill", 32'({s.err, s.enw, s.done}), 32'(3'b100));
    chk("pin_nsteps", 32'({4'(nsteps(CP12)), 4'(nsteps(INV31)), 4'(nsteps(ASR03))}), 32'(12'h123));

    tick();
    tick();
    reset_n = 1'b1;
    exp = idle_rec(last_ir, cnt_m);
    tag = "idle";
    tick();

    do_instr(LD_R2, 1'b0);
    chk("ld_busy_after", 32'(busy), 32'd0);
    do_instr(ADD13, 1'b0);
    do_instr(ADDI, 1'b0);
    chk("addi_imm_idle", 32'(imm), 32'd13);
    do_instr(SUBI, 1'b0);
    do_instr(CP12, 1'b0);
    do_instr(INV31, 1'b0);
    do_instr(XOR21, 1'b1);
    do_instr(ASR03, 1'b0);
    do_instr(ILL10, 1'b0);
    do_instr(ILLOP, 1'b0);
    do_instr(ADD13, 1'b1);

    // Reset asserted during T2 of an add
    exp = idle_rec(last_ir, cnt_m);
    run = 1'b1; instr = ADD13;
    tick();
    run = 1'b0; last_ir = ADD13;
    exp = step_of(ADD13, 0, cnt_m);
    tag = "rst_t1";
    tick();
    reset_n = 1'b0;
    exp = '0;
    tag = "rst_mid";
    tick();
    reset_n = 1'b1;
    cnt_m = 0; last_ir = '0;
    exp = idle_rec(last_ir, cnt_m);
    tag = "post_rst";
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_cnt", 32'(instr_cnt), 32'd0);
    tick();

    for (int n = 0; n < 17; n++) do_instr(CP12, 1'b0);
`ifdef PROC_CTRL_PERF_CNT_EN
    chk("cnt_wrap17", 32'(instr_cnt), 32'd1);
`else
    chk("cnt_absent", 32'(instr_cnt), 32'd0);
`endif
    tick();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
